canny_frame_ctrl: RTL and testbench
===================================

// Module: canny_frame_ctrl
// PURPOSE
// - Frame sequencer/config controller for the Canny chain (gauss -> sobel -> NMS -> hysteresis).
// - Tracks frame/line position from the video sync, flags 3x3-window border pixels, detects malformed frames.
// - Double-buffers hysteresis thresholds and mode bits so config changes take effect only at frame start.
// PARAMETERS
// - H_ACT        640  active pixels per line
// - V_ACT        480  active lines per frame
// - BORDER       1    border width in pixels (3x3 window => 1)
// - X_W          11   pix_x width, 2^X_W > H_ACT
// - Y_W          10   pix_y width, 2^Y_W > V_ACT
// - TH_LOW_DEF   40   reset value of low threshold
// - TH_HIGH_DEF  80   reset value of high threshold
// PORTS
// - clk         in   1    pixel clock
// - rst         in   1    synchronous reset, active-high
// - vs,hs,de    in   1    input video sync; vs active-high, rising edge = frame start
// - cfg_wr      in   1    config write strobe, one write per cycle
// - cfg_addr    in   2    0:th_low 1:th_high 2:ctrl{bypass[1],enable[0]} 3:err_clr(wdata[0])
// - cfg_wdata   in   8    write data
// - vs_o,hs_o,de_o out 1  sync delayed 1 clk (aligned with pix_x/pix_y/border)
// - pix_x       out  X_W  column of current de_o pixel
// - pix_y       out  Y_W  row of current de_o pixel
// - border      out  1    de_o pixel lies within BORDER of any frame edge
// - th_low,th_high out 8  active (shadow) thresholds for the hysteresis stage
// - bypass      out  1    active bypass bit: downstream passes Mxy unthresholded
// - frame_done  out  1    1-clk pulse after the V_ACT-th line ends
// - line_err    out  1    sticky: a line had de count != H_ACT
// - frame_err   out  1    sticky: vs rose mid-frame, or vs rose in FRAME_END before V_ACT lines seen
// BEHAVIOUR
// - Reset: all outputs 0 except th_low=TH_LOW_DEF, th_high=TH_HIGH_DEF. Pending regs same values, enable=1, bypass=0. State IDLE.
// - Edge detect: vs/de registered once internally; vs_rise = vs & ~vs_d, de_fall = ~de & de_d.
// - FSM states: IDLE -> (vs_rise & enable) -> WAIT_DE -> (de) -> ACTIVE -> (de_fall) -> BLANK.
// - BLANK -> (de) -> ACTIVE. BLANK -> (line count == V_ACT) -> FRAME_END, frame_done pulses on that transition.
// - FRAME_END -> (vs_rise) -> WAIT_DE (new frame). Clearing enable only takes effect at the next vs_rise (-> IDLE).
// - Shadow load on every vs_rise with enable=1: th_low/th_high/bypass <= pending.
//   - If pending th_low > th_high, load th_low = th_high (clamp).
//   - cfg_wr in the same cycle as vs_rise: pending updated, shadow gets the OLD pending value.
// - Counters: x increments per de cycle in ACTIVE; on de_fall, y increments and x clears.
//   - line_err sets if x != H_ACT on de_fall.
// - vs_rise in WAIT_DE/ACTIVE/BLANK: frame_err sets, counters clear, shadow load, go to WAIT_DE.
// - de asserted in FRAME_END or IDLE: ignored; de_o still passes, pix_x/pix_y hold 0, border=0.
// - x saturates at 2^X_W-1; no wrap.
// - border = de_o & (x<BORDER | x>=H_ACT-BORDER | y<BORDER | y>=V_ACT-BORDER), computed on registered x/y.
// - Latency: input to all position outputs is exactly 1 clk.
// - err_clr write (addr 3, wdata[0]=1) clears both sticky errors. A same-cycle set wins over clear.
// - Reset mid-frame: immediate return to IDLE, no frame_done, errors cleared.
// STRUCTURE
// - Shared package canny_pkg: FSM state encoding (IDLE, WAIT_DE, ACTIVE, BLANK, FRAME_END), cfg address constants, default thresholds.
// - One natural sub-module: canny_cfg_regs (pending + shadow regs, clamp, err_clr decode). FSM and counters stay in top.
// TESTING
// - Reset, then one 640x480 frame: frame_done pulses once, 1 clk after last de_fall. border=1 at (0,y), (639,y), (x,0), (x,479). border=0 at (1,1). line_err=0.
// - Write th_low=100, th_high=50 mid-frame: outputs stay 40/80 until next vs_rise, then 50/50 (clamped).
// - Write th_high=120 in the same cycle as vs_rise: that frame keeps the old value, next frame shows 120.
// - One line with 639 de cycles: line_err=1 and stays 1. Then err_clr write: line_err=0 next clk.
// - vs_rise after line 200: frame_err=1, pix_y restarts at 0, no frame_done for the aborted frame.
// - enable=0 written mid-frame: current frame completes with frame_done. After next vs_rise, de pulses give pix_x=0, border=0, no frame_done.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared definitions for the Canny frame controller: FSM encoding,
// config register map, default geometry and threshold reset values.
package canny_pkg;

  localparam int H_ACT_DEF  = 640;
  localparam int V_ACT_DEF  = 480;
  localparam int BORDER_DEF = 1;
  localparam int X_W        = 11;
  localparam int Y_W        = 10;

  localparam logic [7:0] TH_LOW_RST  = 8'd40;
  localparam logic [7:0] TH_HIGH_RST = 8'd80;

  localparam logic [1:0] CFG_TH_LOW  = 2'd0;
  localparam logic [1:0] CFG_TH_HIGH = 2'd1;
  localparam logic [1:0] CFG_CTRL    = 2'd2;
  localparam logic [1:0] CFG_ERR_CLR = 2'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DE   = 3'd1,
    ACTIVE    = 3'd2,
    BLANK     = 3'd3,
    FRAME_END = 3'd4
  } state_t;

  // A low threshold above the high one would make hysteresis meaningless,
  // so it is pulled down to the high threshold.
  function automatic logic [7:0] clamp_low(input logic [7:0] lo, input logic [7:0] hi);
    return (lo > hi) ? hi : lo;
  endfunction

endpackage

// File: rtl/canny_frame_ctrl_if.sv
// Video sync, config bus and position/status outputs of the frame controller.
// Config bus: cfg_wr is a single-cycle write strobe with no back-pressure;
// cfg_addr/cfg_wdata are sampled on every clock edge where cfg_wr is high,
// one write per cycle, and the write is always accepted.
interface canny_frame_ctrl_if;
  import canny_pkg::*;

  logic             vs, hs, de;
  logic             cfg_wr;
  logic [1:0]       cfg_addr;
  logic [7:0]       cfg_wdata;
  logic             vs_o, hs_o, de_o;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;
  logic             border;
  logic [7:0]       th_low, th_high;
  logic             bypass;
  logic             frame_done;
  logic             line_err;
  logic             frame_err;

  modport master (
    output vs, hs, de, cfg_wr, cfg_addr, cfg_wdata,
    input  vs_o, hs_o, de_o, pix_x, pix_y, border, th_low, th_high,
           bypass, frame_done, line_err, frame_err
  );

  modport slave (
    input  vs, hs, de, cfg_wr, cfg_addr, cfg_wdata,
    output vs_o, hs_o, de_o, pix_x, pix_y, border, th_low, th_high,
           bypass, frame_done, line_err, frame_err
  );

endinterface

// File: rtl/canny_cfg_regs.sv
// Pending config registers written by the host, plus shadow copies that
// the pipeline actually uses; shadows only load at an enabled frame start.
module canny_cfg_regs
  import canny_pkg::*;
#(
  parameter logic [7:0] LOW_INIT  = TH_LOW_RST,
  parameter logic [7:0] HIGH_INIT = TH_HIGH_RST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  input  logic       load,
  output logic       enable,
  output logic [7:0] th_low,
  output logic [7:0] th_high,
  output logic       bypass,
  output logic       err_clr
);

  logic [7:0] pend_low_q, pend_low_d, pend_high_q, pend_high_d;
  logic       pend_en_q, pend_en_d, pend_byp_q, pend_byp_d;
  logic [7:0] shd_low_q, shd_low_d, shd_high_q, shd_high_d;
  logic       shd_byp_q, shd_byp_d;

  // Host writes update pending; a load copies the pre-write pending values.
  always_comb begin
    pend_low_d  = pend_low_q;
    pend_high_d = pend_high_q;
    pend_en_d   = pend_en_q;
    pend_byp_d  = pend_byp_q;
    shd_low_d   = shd_low_q;
    shd_high_d  = shd_high_q;
    shd_byp_d   = shd_byp_q;
    if (cfg_wr) begin
      unique case (cfg_addr)
        CFG_TH_LOW:  pend_low_d  = cfg_wdata;
        CFG_TH_HIGH: pend_high_d = cfg_wdata;
        CFG_CTRL: begin
          pend_en_d  = cfg_wdata[0];
          pend_byp_d = cfg_wdata[1];
        end
        default: ;
      endcase
    end
    if (load) begin
      shd_low_d  = clamp_low(pend_low_q, pend_high_q);
      shd_high_d = pend_high_q;
      shd_byp_d  = pend_byp_q;
    end
  end

  // Register state with synchronous reset to the default configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_low_q  <= LOW_INIT;
      pend_high_q <= HIGH_INIT;
      pend_en_q   <= 1'b1;
      pend_byp_q  <= 1'b0;
      shd_low_q   <= LOW_INIT;
      shd_high_q  <= HIGH_INIT;
      shd_byp_q   <= 1'b0;
    end else begin
      pend_low_q  <= pend_low_d;
      pend_high_q <= pend_high_d;
      pend_en_q   <= pend_en_d;
      pend_byp_q  <= pend_byp_d;
      shd_low_q   <= shd_low_d;
      shd_high_q  <= shd_high_d;
      shd_byp_q   <= shd_byp_d;
    end
  end

  assign enable  = pend_en_q;
  assign th_low  = shd_low_q;
  assign th_high = shd_high_q;
  assign bypass  = shd_byp_q;
  assign err_clr = cfg_wr && (cfg_addr == CFG_ERR_CLR) && cfg_wdata[0];

endmodule

// File: rtl/canny_frame_ctrl.sv
// Frame sequencer for the Canny chain: tracks pixel position from the video
// sync, flags 3x3-window border pixels and records malformed lines/frames.
module canny_frame_ctrl
  import canny_pkg::*;
#(
  parameter int         H_ACT       = H_ACT_DEF,
  parameter int         V_ACT       = V_ACT_DEF,
  parameter int         BORDER      = BORDER_DEF,
  parameter logic [7:0] TH_LOW_DEF  = TH_LOW_RST,
  parameter logic [7:0] TH_HIGH_DEF = TH_HIGH_RST
) (
  input  logic              clk,
  input  logic              rst,
  canny_frame_ctrl_if.slave bus,
  output state_t            state_dbg
);

  localparam logic [X_W-1:0] H_ACT_X = X_W'(H_ACT);
  localparam logic [X_W-1:0] BRD_X   = X_W'(BORDER);
  localparam logic [Y_W-1:0] V_ACT_Y = Y_W'(V_ACT);
  localparam logic [Y_W-1:0] BRD_Y   = Y_W'(BORDER);

  state_t         state_q, state_d;
  logic           vs_dly_q, vs_dly_d, hs_dly_q, hs_dly_d, de_dly_q, de_dly_d;
  logic [X_W-1:0] x_q, x_d, pix_x_q, pix_x_d;
  logic [Y_W-1:0] y_q, y_d, pix_y_q, pix_y_d;
  logic           border_q, border_d;
  logic           line_err_q, line_err_d, frame_err_q, frame_err_d;
  logic           enable, err_clr, frame_done;
  logic           vs_rise, de_fall, in_frame, last_line, count_pix;
  logic           line_set, frame_set;

  canny_cfg_regs #(
    .LOW_INIT  (TH_LOW_DEF),
    .HIGH_INIT (TH_HIGH_DEF)
  ) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .cfg_wr    (bus.cfg_wr),
    .cfg_addr  (bus.cfg_addr),
    .cfg_wdata (bus.cfg_wdata),
    .load      (vs_rise & enable),
    .enable    (enable),
    .th_low    (bus.th_low),
    .th_high   (bus.th_high),
    .bypass    (bus.bypass),
    .err_clr   (err_clr)
  );

  // Sync edge events and frame-position qualifiers.
  always_comb begin
    vs_rise   = bus.vs & ~vs_dly_q;
    de_fall   = ~bus.de & de_dly_q;
    in_frame  = (state_q == WAIT_DE) || (state_q == ACTIVE) || (state_q == BLANK);
    last_line = (state_q == BLANK) && (y_q == V_ACT_Y);
    count_pix = bus.de & in_frame & ~vs_rise;
  end

  // Next-state: a new frame start overrides everything except IDLE's own entry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (vs_rise && enable) state_d = WAIT_DE;
      WAIT_DE:   if (bus.de) state_d = ACTIVE;
      ACTIVE:    if (de_fall) state_d = BLANK;
      BLANK:     if (last_line) state_d = FRAME_END;
                 else if (bus.de) state_d = ACTIVE;
      FRAME_END: ;
      default:   state_d = IDLE;
    endcase
    if (vs_rise && state_q != IDLE) state_d = enable ? WAIT_DE : IDLE;
  end

  // FSM outputs: frame_done marks the single BLANK cycle after the last line.
  always_comb begin
    frame_done = last_line & ~rst;
    state_dbg  = state_q;
  end

  // Position counters, registered position outputs and sticky errors.
  always_comb begin
    vs_dly_d = bus.vs;
    hs_dly_d = bus.hs;
    de_dly_d = bus.de;
    x_d      = x_q;
    y_d      = y_q;
    line_set = 1'b0;
    if (vs_rise || state_q == IDLE) begin
      x_d = '0;
      y_d = '0;
    end else if (state_q == ACTIVE && de_fall) begin
      line_set = (x_q != H_ACT_X);
      x_d      = '0;
      y_d      = y_q + 1'b1;
    end else if (count_pix) begin
      x_d = (x_q == '1) ? x_q : x_q + 1'b1;
    end
    pix_x_d  = count_pix ? x_q : '0;
    pix_y_d  = count_pix ? y_q : '0;
    border_d = count_pix & ((x_q < BRD_X) | (x_q >= H_ACT_X - BRD_X) |
                            (y_q < BRD_Y) | (y_q >= V_ACT_Y - BRD_Y));
    // A vs edge right after the final line is a clean frame boundary.
    frame_set   = vs_rise & in_frame & ~last_line;
    line_err_d  = line_set  | (line_err_q  & ~err_clr);
    frame_err_d = frame_set | (frame_err_q & ~err_clr);
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vs_dly_q    <= 1'b0;
      hs_dly_q    <= 1'b0;
      de_dly_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      border_q    <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_dly_q    <= vs_dly_d;
      hs_dly_q    <= hs_dly_d;
      de_dly_q    <= de_dly_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      border_q    <= border_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.vs_o       = vs_dly_q;
  assign bus.hs_o       = hs_dly_q;
  assign bus.de_o       = de_dly_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;
  assign bus.border     = border_q;
  assign bus.frame_done = frame_done;
  assign bus.line_err   = line_err_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Bench for canny_frame_ctrl on a reduced 32x24 geometry.
module tb_canny_frame_ctrl;
  import canny_pkg::*;

  localparam int HA  = 32;
  localparam int VA  = 24;
  localparam int BLK = 4;
  localparam int W   = 22;

  logic   clk = 1'b0;
  logic   rst;
  state_t state_dbg;

  canny_frame_ctrl_if bus ();

  canny_frame_ctrl #(
    .H_ACT       (HA),
    .V_ACT       (VA),
    .BORDER      (1),
    .TH_LOW_DEF  (8'd40),
    .TH_HIGH_DEF (8'd80)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock and counters.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int fd_cnt   = 0;
  int fd_cyc   = -1;
  int fall_cyc = 0;
  int cur_y    = 0;
  bit trk      = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  // Expected {pix_x, pix_y, border} for a pixel the bench drives.
  function automatic logic [W-1:0] pix_exp(input int x, input int y);
    int   xs;
    logic b;
    xs = (x > 2047) ? 2047 : x;
    b  = (xs < 1) || (xs >= HA - 1) || (y < 1) || (y >= VA - 1);
    return {11'(xs), 10'(y), b};
  endfunction

  // One clock: inputs set before the call are registered; outputs are
  // sampled 1 time unit after the edge and matched against the scoreboard.
  task automatic step();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (!rst && bus.de_o) begin
      if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("pixel", {10'd0, bus.pix_x, bus.pix_y, bus.border}, {10'd0, e});
      end
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    bus.cfg_wr = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    step();
    bus.cfg_wr = 1'b0;
  endtask

  // vs pulse, optionally with a config write in the vs_rise cycle.
  task automatic vs_pulse(input bit wr, input logic [1:0] a, input logic [7:0] d);
    bus.vs = 1'b1;
    bus.cfg_wr = wr; bus.cfg_addr = a; bus.cfg_wdata = d;
    step();
    chk("vs_o", bus.vs_o, 1);
    bus.vs = 1'b0; bus.cfg_wr = 1'b0;
    step();
    step();
    cur_y = 0;
  endtask

  task automatic drive_line(input int n);
    for (int i = 0; i < n; i++) begin
      bus.de = 1'b1;
      exp_q.push_back(trk ? pix_exp(i, cur_y) : '0);
      step();
    end
    bus.de = 1'b0;
    fall_cyc = cyc;
    for (int i = 0; i < BLK; i++) begin
      bus.hs = (i == 1);
      step();
      chk("hs_o", bus.hs_o, (i == 1));
    end
    cur_y++;
  endtask

  // Stimulus sequence.
  initial begin
    rst = 1'b1;
    bus.vs = 1'b0; bus.hs = 1'b0; bus.de = 1'b0;
    bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    repeat (3) step();
    chk("rst_state", state_dbg, IDLE);
    chk("rst_th_low", bus.th_low, 40);
    chk("rst_th_high", bus.th_high, 80);
    chk("rst_bypass", bus.bypass, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_line_err", bus.line_err, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_pix", {bus.de_o, bus.pix_x, bus.pix_y, bus.border}, 0);
    rst = 1'b0;
    step();

    // Frame A: clean frame, inverted thresholds written mid-frame.
    trk = 1'b1;
    vs_pulse(1'b0, 2'd0, 8'd0);
    chk("a_state", state_dbg, WAIT_DE);
    for (int y = 0; y < VA; y++) begin
      drive_line(HA);
      if (y == 5) begin
        cfg_write(CFG_TH_LOW, 8'd100);
        cfg_write(CFG_TH_HIGH, 8'd50);
        chk("a_th_low_held", bus.th_low, 40);
        chk("a_th_high_held", bus.th_high, 80);
      end
      if (y == VA - 2) chk("a_no_early_done", fd_cnt, 0);
    end
    chk("a_done_cnt", fd_cnt, 1);
    chk("a_done_cyc", fd_cyc, fall_cyc + 1);
    chk("a_line_err", bus.line_err, 0);
    chk("a_frame_err", bus.frame_err, 0);
    chk("a_state_end", state_dbg, FRAME_END);
    chk("a_th_low_end", bus.th_low, 40);

    // Frame B: clamped thresholds, one short line, then error clear.
    vs_pulse(1'b0, 2'd0, 8'd0);
    chk("b_th_low", bus.th_low, 50);
    chk("b_th_high", bus.th_high, 50);
    chk("b_frame_err", bus.frame_err, 0);
    for (int y = 0; y < VA; y++) begin
      drive_line((y == 3) ? HA - 1 : HA);
      if (y == 3) chk("b_line_err_set", bus.line_err, 1);
      if (y == 6) chk("b_line_err_sticky", bus.line_err, 1);
      if (y == 8) begin
        cfg_write(CFG_ERR_CLR, 8'd1);
        chk("b_line_err_clr", bus.line_err, 0);
      end
    end
    chk("b_done_cnt", fd_cnt, 2);

    // Frame C: th_high written in the vs_rise cycle; aborted after 12 lines.
    vs_pulse(1'b1, CFG_TH_HIGH, 8'd120);
    chk("c_th_low", bus.th_low, 50);
    chk("c_th_high_old", bus.th_high, 50);
    cfg_write(CFG_CTRL, 8'h03);
    for (int y = 0; y < 12; y++) drive_line(HA);
    chk("c_th_high_mid", bus.th_high, 50);
    chk("c_bypass_mid", bus.bypass, 0);

    // Frame D: starts over frame C, then enable cleared mid-frame.
    vs_pulse(1'b0, 2'd0, 8'd0);
    chk("d_frame_err", bus.frame_err, 1);
    chk("d_done_cnt_abort", fd_cnt, 2);
    chk("d_state", state_dbg, WAIT_DE);
    chk("d_th_low", bus.th_low, 100);
    chk("d_th_high", bus.th_high, 120);
    chk("d_bypass", bus.bypass, 1);
    for (int y = 0; y < VA; y++) begin
      drive_line(HA);
      if (y == 2) begin
        cfg_write(CFG_ERR_CLR, 8'd1);
        chk("d_frame_err_clr", bus.frame_err, 0);
      end
      if (y == 4) cfg_write(CFG_CTRL, 8'h00);
    end
    chk("d_done_cnt", fd_cnt, 3);

    // Frame E: disabled, de pulses pass through without position.
    trk = 1'b0;
    vs_pulse(1'b0, 2'd0, 8'd0);
    chk("e_state", state_dbg, IDLE);
    chk("e_bypass_kept", bus.bypass, 1);
    chk("e_frame_err", bus.frame_err, 0);
    for (int y = 0; y < 3; y++) drive_line(HA);
    chk("e_done_cnt", fd_cnt, 3);
    chk("e_line_err", bus.line_err, 0);

    // Re-enable, overlong line saturates pix_x, then reset mid-frame.
    cfg_write(CFG_CTRL, 8'h01);
    trk = 1'b1;
    vs_pulse(1'b0, 2'd0, 8'd0);
    chk("s_state", state_dbg, WAIT_DE);
    chk("s_bypass", bus.bypass, 0);
    drive_line(2100);
    chk("s_line_err", bus.line_err, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_state", state_dbg, IDLE);
    chk("r_line_err", bus.line_err, 0);
    chk("r_th_low", bus.th_low, 40);
    chk("r_th_high", bus.th_high, 80);
    repeat (3) step();
    chk("r_done_cnt", fd_cnt, 3);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
